counter_seconds: RTL and testbench
==================================

Name: counter_seconds

Overview:
- Seconds stage of the clock time chain.
- Holds a BCD seconds value 00..59 as separate unit and tens digits.
- Run mode: advances one second per clock and emits a one-cycle tick_minute at each 59->00 rollover, which drives the minutes stage.
- Set mode: the user adjusts the value with up/down controls; no carry is generated.

Parameters:
- None. The modulus is fixed at 60 and the encoding at BCD.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- mode_second  input  1  1 = run (count) mode, 0 = set/adjust mode.
- up  input  1  set mode only: increment request, level-sensitive.
- down  input  1  set mode only: decrement request, level-sensitive.
- second_unit  output  4  BCD units digit, 0..9, registered.
- second_ten  output  4  BCD tens digit, 0..5, registered.
- tick_minute  output  1  registered one-cycle pulse on run-mode rollover 59->00.

Behaviour:
- Reset (rst_n=0, asynchronous): second_unit=0, second_ten=0, tick_minute=0 immediately. They hold while reset is low. The first update occurs on the first rising clk edge after rst_n rises.
- All logic is in one clock domain. There is no separate enable: every clock edge in run mode is one second.
- Run mode (mode_second=1):
  - Each edge, value +1.
  - Units digit 9 -> units 0, tens +1.
  - At 59 -> 00.
  - up and down are ignored.
- tick_minute:
  - Set to 1 on the same edge that loads 00 from 59 in run mode; otherwise 0 on every edge.
  - Consequently it is high for exactly one cycle, coincident with the outputs reading 00.
  - Never asserted in set mode or during reset.
- Set mode (mode_second=0), evaluated each edge:
  - up=1, down=0: value +1 modulo 60 (59 -> 00), no tick.
  - up=0, down=1: value -1 modulo 60. Units 0 -> 9 with tens -1; 00 -> 59. No tick.
  - up=down=0: hold.
  - up=down=1: hold (conflicting request).
  - Level-sensitive: a held request steps once per clock. No edge detection.
- Mode switching takes effect on the next edge. There is no latency beyond one register stage and no pipeline.
- Outputs are always valid BCD: unit never exceeds 9 and ten never exceeds 5. Any illegal state (unreachable) must recover to 00 on the next edge.
- Reset asserted mid-count or mid-pulse clears everything asynchronously, including an in-flight tick_minute.

Test Plan:
- Hold rst_n=0 for 20 ns -> outputs 0/0, tick_minute=0. Drop rst_n mid-cycle later -> immediate clear.
- Release reset with mode_second=1, up=down=0, run 65 edges:
  - edge n shows n mod 60 in BCD;
  - edge 60 shows ten=0, unit=0 with tick_minute=1 for that cycle only;
  - after 65 edges value = 05.
- mode_second=0, up=down=1 for 65 edges -> value stays 05, tick_minute=0 throughout.
- mode_second=0, up=1, down=0 for 65 edges from 05:
  - passes 09 -> 10 and 59 -> 00;
  - ends at 10 (ten=1, unit=0);
  - tick_minute never asserts.
- mode_second=0, up=down=0 for 65 edges -> holds 10.
- mode_second=0, up=0, down=1 for 65 edges from 10:
  - passes 10 -> 09 and 00 -> 59;
  - ends at 05;
  - no tick.
- Throughout all scenarios: second_unit<=9 and second_ten<=5 every cycle.

Source files
------------

// File: rtl/counter_seconds.sv
// -----------------------------------------------------------------------------
// counter_seconds
//
// Seconds stage of the clock time chain. Holds a BCD seconds value 00..59 as
// separate units and tens digits.
//
//   Run mode : the value advances by one on every clock edge. A registered
//              one-cycle tick_minute pulse accompanies the 59 -> 00 rollover
//              and feeds the minutes stage.
//   Set mode : the value is adjusted by level-sensitive up/down requests,
//              one step per clock, wrapping modulo 60. No carry is produced.
//
// Ports
//   clk          in   1  system clock, rising-edge active
//   rst_n        in   1  asynchronous active-low reset
//   mode_second  in   1  1 = run (count), 0 = set/adjust
//   up           in   1  set mode: step up while high
//   down         in   1  set mode: step down while high
//   second_unit  out  4  BCD units digit 0..9 (registered)
//   second_ten   out  4  BCD tens digit 0..5 (registered)
//   tick_minute  out  1  one-cycle pulse coincident with the run-mode 00
// -----------------------------------------------------------------------------
module counter_seconds (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode_second,
    input  logic       up,
    input  logic       down,
    output logic [3:0] second_unit,
    output logic [3:0] second_ten,
    output logic       tick_minute
);

    // Operation selected for the coming edge.
    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_INC  = 2'd1,
        OP_DEC  = 2'd2,
        OP_RUN  = 2'd3
    } op_e;

    // A BCD seconds value.
    typedef struct packed {
        logic [3:0] ten;
        logic [3:0] unit;
    } bcd_t;

    localparam bcd_t BCD_ZERO = '{ten: 4'd0, unit: 4'd0};
    localparam bcd_t BCD_MAX  = '{ten: 4'd5, unit: 4'd9};

    // -------------------------------------------------------------------------
    // BCD arithmetic helpers
    // -------------------------------------------------------------------------

    // True when both digits are inside their legal ranges.
    function automatic logic bcd_is_legal(input bcd_t v);
        return (v.unit <= 4'd9) && (v.ten <= 4'd5);
    endfunction

    // +1 modulo 60.
    function automatic bcd_t bcd_inc(input bcd_t v);
        bcd_t r;
        r = v;
        if (v.unit == 4'd9) begin
            r.unit = 4'd0;
            r.ten  = (v.ten == 4'd5) ? 4'd0 : v.ten + 4'd1;
        end else begin
            r.unit = v.unit + 4'd1;
        end
        return r;
    endfunction

    // -1 modulo 60.
    function automatic bcd_t bcd_dec(input bcd_t v);
        bcd_t r;
        r = v;
        if (v.unit == 4'd0) begin
            r.unit = 4'd9;
            r.ten  = (v.ten == 4'd0) ? 4'd5 : v.ten - 4'd1;
        end else begin
            r.unit = v.unit - 4'd1;
        end
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    bcd_t value_q;
    bcd_t value_d;
    logic tick_q;
    logic tick_d;
    op_e  op;

    // -------------------------------------------------------------------------
    // Operation decode
    // -------------------------------------------------------------------------
    // Run mode ignores up/down entirely. In set mode a simultaneous up and
    // down is treated as a conflicting request and holds the value.
    always_comb begin
        // NOTE: every variable assigned in a combinational block gets a
        // default first so that no path leaves it unassigned (no latch).
        op = OP_HOLD;
        if (mode_second) begin
            op = OP_RUN;
        end else if (up && !down) begin
            op = OP_INC;
        end else if (down && !up) begin
            op = OP_DEC;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        value_d = value_q;
        tick_d  = 1'b0;

        if (!bcd_is_legal(value_q)) begin
            // Unreachable in normal operation; force a clean 00 so the
            // outputs are valid BCD again after one edge.
            value_d = BCD_ZERO;
        end else begin
            unique case (op)
                OP_RUN: begin
                    value_d = bcd_inc(value_q);
                    // The pulse is registered together with the 00 it
                    // announces, so downstream sees both in the same cycle.
                    tick_d  = (value_q == BCD_MAX);
                end
                OP_INC:  value_d = bcd_inc(value_q);
                OP_DEC:  value_d = bcd_dec(value_q);
                OP_HOLD: value_d = value_q;
                default: value_d = value_q;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so that
    // every register samples the pre-edge values of its inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= BCD_ZERO;
            tick_q  <= 1'b0;
        end else begin
            value_q <= value_d;
            tick_q  <= tick_d;
        end
    end

    assign second_unit = value_q.unit;
    assign second_ten  = value_q.ten;
    assign tick_minute = tick_q;

endmodule

// File: tb/tb_counter_seconds.sv
// -----------------------------------------------------------------------------
// tb_counter_seconds
//
// Self-checking bench for counter_seconds. A table of {inputs, expected}
// records is built up front from an integer seconds model (value kept as
// 0..59 and converted to BCD with /10 and %10). Each record is applied at the
// falling edge; its expectation is pushed to a scoreboard queue and popped
// for comparison just after the following rising edge. Hand-written
// sequences cover reset behaviour and reset in the middle of a tick pulse.
// -----------------------------------------------------------------------------
module tb_counter_seconds;

    typedef struct {
        logic       mode;
        logic       up;
        logic       down;
        logic [3:0] exp_unit;
        logic [3:0] exp_ten;
        logic       exp_tick;
    } vec_t;

    typedef struct {
        logic [3:0] unit;
        logic [3:0] ten;
        logic       tick;
        string      tag;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       mode_second;
    logic       up;
    logic       down;
    logic [3:0] second_unit;
    logic [3:0] second_ten;
    logic       tick_minute;

    int   tests_run;
    int   tests_failed;
    int   model_val;
    vec_t vecs[$];
    exp_t sb[$];

    counter_seconds dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mode_second (mode_second),
        .up          (up),
        .down        (down),
        .second_unit (second_unit),
        .second_ten  (second_ten),
        .tick_minute (tick_minute)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Comparison helper
    // -------------------------------------------------------------------------
    task automatic check(input string name, input int actual, input int expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model: advance model_val by one edge, return expected tick.
    // -------------------------------------------------------------------------
    function automatic logic model_step(input logic mode, input logic u, input logic d);
        logic t;
        t = 1'b0;
        if (mode) begin
            model_val = (model_val + 1) % 60;
            t = (model_val == 0);
        end else if (u && !d) begin
            model_val = (model_val + 1) % 60;
        end else if (d && !u) begin
            model_val = (model_val + 59) % 60;
        end
        return t;
    endfunction

    task automatic add_segment(input logic mode, input logic u, input logic d, input int n);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v.mode     = mode;
            v.up       = u;
            v.down     = d;
            v.exp_tick = model_step(mode, u, d);
            v.exp_unit = 4'(model_val % 10);
            v.exp_ten  = 4'(model_val / 10);
            vecs.push_back(v);
        end
    endtask

    // Drive one edge worth of inputs at the falling edge, push the expectation,
    // then pop and compare just after the rising edge.
    task automatic apply(input logic mode, input logic u, input logic d,
                         input logic [3:0] e_unit, input logic [3:0] e_ten,
                         input logic e_tick, input string tag);
        exp_t e;
        exp_t got;
        mode_second = mode;
        up          = u;
        down        = d;
        e.unit = e_unit;
        e.ten  = e_ten;
        e.tick = e_tick;
        e.tag  = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, " scoreboard_empty"}, 1, 0);
        end else begin
            got = sb.pop_front();
            check({got.tag, " unit"}, int'(second_unit), int'(got.unit));
            check({got.tag, " ten"},  int'(second_ten),  int'(got.ten));
            check({got.tag, " tick"}, int'(tick_minute), int'(got.tick));
            check({got.tag, " unit_range"}, int'(second_unit <= 4'd9), 1);
            check({got.tag, " ten_range"},  int'(second_ten  <= 4'd5), 1);
        end
        @(negedge clk);
    endtask

    // Step using the live model (hand-written sequences).
    task automatic model_apply(input logic mode, input logic u, input logic d, input string tag);
        logic t;
        t = model_step(mode, u, d);
        apply(mode, u, d, 4'(model_val % 10), 4'(model_val / 10), t, tag);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        mode_second  = 1'b1;
        up           = 1'b0;
        down         = 1'b0;

        // ---- Build the vector table from the model, starting at 00 ----
        model_val = 0;
        add_segment(1'b1, 1'b0, 1'b0, 65);  // run: 01..59,00(tick),01..05
        add_segment(1'b0, 1'b1, 1'b1, 65);  // conflict: hold 05
        add_segment(1'b0, 1'b1, 1'b0, 65);  // up: 05 -> 10 via 59->00
        add_segment(1'b0, 1'b0, 1'b0, 65);  // idle: hold 10
        add_segment(1'b0, 1'b0, 1'b1, 65);  // down: 10 -> 05 via 00->59
        add_segment(1'b1, 1'b1, 1'b0, 3);   // run ignores up
        add_segment(1'b1, 1'b0, 1'b1, 2);   // run ignores down

        // ---- Reset held for 20 ns ----
        #20;
        check("reset unit", int'(second_unit), 0);
        check("reset ten",  int'(second_ten),  0);
        check("reset tick", int'(tick_minute), 0);

        // Release reset away from the rising edge (t=20 is a falling edge).
        rst_n = 1'b1;

        // ---- Table-driven run ----
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].mode, vecs[i].up, vecs[i].down,
                  vecs[i].exp_unit, vecs[i].exp_ten, vecs[i].exp_tick,
                  $sformatf("vec%0d", i));
        end

        // ---- Reset in the middle of a tick pulse ----
        // model_val continues from the end of the table (10).
        while (model_val != 59) begin
            model_apply(1'b1, 1'b0, 1'b0, "to59");
        end
        model_apply(1'b1, 1'b0, 1'b0, "rollover");   // shows 00 with tick=1
        check("pre_reset tick_high", int'(tick_minute), 1);

        // Now just after the falling edge; drop reset mid-cycle.
        #2;
        rst_n = 1'b0;
        #1;
        check("midcycle_reset tick", int'(tick_minute), 0);
        check("midcycle_reset unit", int'(second_unit), 0);
        check("midcycle_reset ten",  int'(second_ten),  0);

        // Reset must hold through rising edges even in run mode.
        mode_second = 1'b1;
        @(posedge clk);
        #1;
        check("reset_hold unit", int'(second_unit), 0);
        check("reset_hold tick", int'(tick_minute), 0);
        @(negedge clk);
        rst_n     = 1'b1;
        model_val = 0;
        model_apply(1'b1, 1'b0, 1'b0, "post_reset_first");  // 01
        model_apply(1'b1, 1'b0, 1'b0, "post_reset_second"); // 02

        // ---- Drop reset mid-count (not during a pulse) ----
        #3;
        rst_n = 1'b0;
        #1;
        check("midcount_reset unit", int'(second_unit), 0);
        check("midcount_reset ten",  int'(second_ten),  0);
        @(negedge clk);
        rst_n     = 1'b1;
        model_val = 0;

        // ---- Set mode from 00 downward then mode switch to run ----
        model_apply(1'b0, 1'b0, 1'b1, "set_down_00_to_59");
        model_apply(1'b1, 1'b0, 1'b0, "switch_run_59_to_00");
        model_apply(1'b0, 1'b1, 1'b0, "switch_set_up");

        check("scoreboard drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Safety net: the bench must always end by itself.
    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
